branch_resolve_unit: RTL and testbench

Write-side partner of the branch history table. Tracks every fetch-time prediction in an in-order FIFO, checks each one against the resolved outcome in EX, and raises a one-cycle mispredict/flush pulse. Generates the registered table update strobe (write address, was_taken, jumped) that trains the history table's 2-bit counters. Sits between the IF-stage prediction read and the EX-stage branch resolution.

---
 rtl/bp_pkg.sv | 19 +
 rtl/branch_resolve_unit_if.sv | 34 +++
 rtl/bp_pred_fifo.sv | 53 +++++
 rtl/branch_resolve_unit.sv | 85 ++++++++
 tb/tb_branch_resolve_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Types and constants shared by the branch history table and its resolve/update side.
package bp_pkg;

    localparam int LOWER_DEFAULT  = 5;
    localparam int PRED_TAKEN_BIT = 1;

    typedef struct packed {
        logic [LOWER_DEFAULT-1:0] index;
        logic                     pred;
    } bp_entry_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-prediction, EX-resolve and table-update signals of the branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int LOWER = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                       fetch_valid;
    logic [LOWER-1:0]           fetch_index;
    logic                       fetch_pred;
    logic                       fetch_ready;
    logic                       res_valid;
    logic                       res_taken;
    logic                       res_jump;
    logic                       mispredict;
    logic                       bht_we;
    logic [LOWER-1:0]           bht_write_addr;
    logic                       bht_was_taken;
    logic                       bht_jumped;
    logic [$clog2(DEPTH):0]     inflight;
    logic [CNT_W-1:0]           mispredict_cnt;
    logic                       underflow_err;

    modport slave (
        input  fetch_valid, fetch_index, fetch_pred, res_valid, res_taken, res_jump,
        output fetch_ready, mispredict, bht_we, bht_write_addr, bht_was_taken,
               bht_jumped, inflight, mispredict_cnt, underflow_err
    );

    modport master (
        output fetch_valid, fetch_index, fetch_pred, res_valid, res_taken, res_jump,
        input  fetch_ready, mispredict, bht_we, bht_write_addr, bht_was_taken,
               bht_jumped, inflight, mispredict_cnt, underflow_err
    );
endinterface

// File: rtl/bp_pred_fifo.sv
// In-order circular buffer of fetch-time predictions; clear wins over push and pop.
module bp_pred_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Checks each tracked prediction against the EX outcome, pulses mispredict and
// emits the registered history-table update.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int LOWER = LOWER_DEFAULT,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [LOWER:0]   w_head;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_actual;
    logic             w_mis;

    logic             r_mis;
    logic             r_we;
    logic [LOWER-1:0] r_addr;
    logic             r_taken;
    logic             r_jump;
    logic [CNT_W-1:0] r_cnt;
    logic             r_uf;

    assign w_push   = bus.fetch_valid && !w_full;
    assign w_pop    = bus.res_valid && !w_empty;
    assign w_actual = bus.res_taken | bus.res_jump;
    assign w_mis    = w_pop && (w_actual != w_head[0]);

    // A mispredict flushes the wrong-path entries, including any push in the same cycle.
    bp_pred_fifo #(.DEPTH(DEPTH), .W(LOWER+1)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({bus.fetch_index, bus.fetch_pred}),
        .i_pop   (w_pop),
        .i_clear (w_mis),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mis   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_taken <= 1'b0;
            r_jump  <= 1'b0;
            r_cnt   <= '0;
            r_uf    <= 1'b0;
        end else begin
            r_mis <= w_mis;
            r_we  <= w_pop;
            if (w_pop) begin
                r_addr  <= w_head[LOWER:1];
                r_taken <= bus.res_taken;
                r_jump  <= bus.res_jump;
            end
            if (w_mis && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
            if (bus.res_valid && w_empty)
                r_uf <= 1'b1;
        end
    end

    assign bus.fetch_ready    = !w_full;
    assign bus.mispredict     = r_mis;
    assign bus.bht_we         = r_we;
    assign bus.bht_write_addr = r_addr;
    assign bus.bht_was_taken  = r_taken;
    assign bus.bht_jumped     = r_jump;
    assign bus.inflight       = w_count;
    assign bus.mispredict_cnt = r_cnt;
    assign bus.underflow_err  = r_uf;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference FIFO model queues expected updates.
module tb_branch_resolve_unit;
    import bp_pkg::*;

    localparam int LOWER = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    typedef struct {
        logic [LOWER-1:0] addr;
        logic             tk;
        logic             jp;
        logic             mis;
    } exp_t;

    logic clk;
    logic rst;

    branch_resolve_unit_if #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(CNT_W)) bif ();

    branch_resolve_unit #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bp_entry_t mq[$];
    exp_t      exp_q[$];
    int        m_cnt;
    logic      m_uf;
    int        n_cmp;
    int        n_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bht_we", 32'(bif.bht_we), 32'd1);
            chk("bht_write_addr", 32'(bif.bht_write_addr), 32'(e.addr));
            chk("bht_was_taken", 32'(bif.bht_was_taken), 32'(e.tk));
            chk("bht_jumped", 32'(bif.bht_jumped), 32'(e.jp));
            chk("mispredict", 32'(bif.mispredict), 32'(e.mis));
        end else begin
            chk("bht_we_idle", 32'(bif.bht_we), 32'd0);
            chk("mispredict_idle", 32'(bif.mispredict), 32'd0);
        end
        chk("inflight", 32'(bif.inflight), 32'(mq.size()));
        chk("fetch_ready", 32'(bif.fetch_ready), 32'(mq.size() != DEPTH));
        chk("mispredict_cnt", 32'(bif.mispredict_cnt), 32'(m_cnt));
        chk("underflow_err", 32'(bif.underflow_err), 32'(m_uf));
    endtask

    task automatic step(input logic fv, input logic [LOWER-1:0] fi, input logic fp,
                        input logic rv, input logic rt, input logic rj);
        bp_entry_t h;
        exp_t      e;
        logic      push;
        logic      mis;
        bif.fetch_valid = fv;
        bif.fetch_index = fi;
        bif.fetch_pred  = fp;
        bif.res_valid   = rv;
        bif.res_taken   = rt;
        bif.res_jump    = rj;
        push = fv && (mq.size() != DEPTH);
        mis  = 1'b0;
        if (rv && mq.size() > 0) begin
            h     = mq[0];
            mis   = ((rt | rj) != h.pred);
            e.addr = h.index;
            e.tk   = rt;
            e.jp   = rj;
            e.mis  = mis;
            exp_q.push_back(e);
            void'(mq.pop_front());
        end else if (rv) begin
            m_uf = 1'b1;
        end
        if (mis) begin
            mq.delete();
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (push) begin
            h.index = fi;
            h.pred  = fp;
            mq.push_back(h);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic fv, input logic rv);
        rst             = 1'b1;
        bif.fetch_valid = fv;
        bif.fetch_index = 5'd17;
        bif.fetch_pred  = 1'b1;
        bif.res_valid   = rv;
        bif.res_taken   = 1'b0;
        bif.res_jump    = 1'b0;
        mq.delete();
        exp_q.delete();
        m_cnt = 0;
        m_uf  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
        chk("rst_addr", 32'(bif.bht_write_addr), 32'd0);
        chk("rst_was_taken", 32'(bif.bht_was_taken), 32'd0);
        chk("rst_jumped", 32'(bif.bht_jumped), 32'd0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_cnt = 0;
        m_uf  = 1'b0;
        rst   = 1'b1;
        bif.fetch_valid = 1'b0;
        bif.fetch_index = '0;
        bif.fetch_pred  = 1'b0;
        bif.res_valid   = 1'b0;
        bif.res_taken   = 1'b0;
        bif.res_jump    = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);
        idle();

        // correct taken prediction
        step(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();

        // mispredict flushes idx 7 and drops the same-cycle push of idx 20
        step(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd20, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // fill, then push+pop while full is refused
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(10 + i), 1'(i[0]), 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd30, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd31, 1'b1, 1'b1, mq[0].pred, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b1, 5'(i * 3 + 1), 1'($urandom_range(0, 1)), 1'b1, mq[0].pred, 1'b0);
        while (mq.size() > 0)
            step(1'b0, '0, 1'b0, 1'b1, mq[0].pred, 1'b0);
        idle();

        // unconditional jump against a not-taken prediction
        step(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();

        // counter saturation
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'(21 + i), 1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        idle();

        // reset mid-stream with a resolve pending on the same edge
        step(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
